// File: rtl/bitrev_pp.sv
// bitrev_pp: double-buffered streaming bit-reversal reorder unit.
// Frames are written into one ping-pong bank at bit-reversed addresses while the
// other bank is read out sequentially, so the output appears in bit-reversed order.
module bitrev_pp #(
    parameter int unsigned K  = 10,
    parameter int unsigned DW = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     valid_i,
    input  logic [DW-1:0]            data_i,
    output logic                     ready_o,
    input  logic [$clog2(K+1)-1:0]   cfg_log2n_i,
    input  logic                     cfg_bypass_i,
    output logic                     valid_o,
    output logic [DW-1:0]            data_o,
    output logic                     last_o,
    input  logic                     ready_i
);

    localparam int unsigned LW  = $clog2(K+1);
    localparam int unsigned N   = 1 << K;
    localparam int unsigned KP1 = K + 1;
    localparam int unsigned AW  = K + 1;

    // Out-of-range lengths (0 or above K) select the full bank depth.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        if ((l == '0) || (l > LW'(K))) begin
            return LW'(K);
        end
        return l;
    endfunction

    // Index of the final word of a 2^l frame, i.e. 2^l - 1.
    function automatic logic [K-1:0] last_idx(input logic [LW-1:0] l);
        logic [K:0] t;
        t = (KP1'(1) << l) - KP1'(1);
        return t[K-1:0];
    endfunction

    // Reverse the low l bits of v; bits at or above l are zero in the result.
    function automatic logic [K-1:0] rev_bits(input logic [K-1:0] v, input logic [LW-1:0] l);
        logic [K-1:0] r;
        logic [LW-1:0] sh;
        for (int i = 0; i < int'(K); i++) begin
            r[i] = v[K-1-i];
        end
        sh = LW'(K) - l;
        return r >> sh;
    endfunction

    // Per-bank status and pointers.
    logic [1:0]           full_q, full_d;
    logic [1:0][LW-1:0]   len_q, len_d;
    logic [1:0]           byp_q, byp_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [K-1:0]         wr_cnt_q, wr_cnt_d;
    logic [K-1:0]         rd_cnt_q, rd_cnt_d;

    // Storage; contents are intentionally not reset.
    logic [DW-1:0]        mem_q [2*N];
    logic                 mem_we;
    logic [AW-1:0]        mem_waddr;

    logic                 wr_fire;
    logic                 rd_fire;
    logic                 wr_first;
    logic [LW-1:0]        wr_len;
    logic                 wr_byp;
    logic [K-1:0]         wr_addr;
    logic                 rd_last;
    logic [DW-1:0]        rd_data;

    // Outputs depend on registered state only.
    always_comb begin
        ready_o = ~full_q[wr_bank_q];
        valid_o = full_q[rd_bank_q];
        rd_last = valid_o && (rd_cnt_q == last_idx(len_q[rd_bank_q]));
        rd_data = mem_q[{rd_bank_q, rd_cnt_q}];
        data_o  = valid_o ? rd_data : '0;
        last_o  = rd_last;
    end

    // Next-state for write/read pointers, bank status and storage write port.
    always_comb begin
        full_d    = full_q;
        len_d     = len_q;
        byp_d     = byp_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = '0;

        wr_fire  = valid_i && ready_o;
        rd_fire  = valid_o && ready_i;
        wr_first = (wr_cnt_q == '0);

        // The first word of a frame uses the live config; later words use the latched one.
        wr_len  = wr_first ? clamp_len(cfg_log2n_i) : len_q[wr_bank_q];
        wr_byp  = wr_first ? cfg_bypass_i : byp_q[wr_bank_q];
        wr_addr = wr_byp ? wr_cnt_q : rev_bits(wr_cnt_q, wr_len);

        if (wr_fire) begin
            mem_we    = 1'b1;
            mem_waddr = {wr_bank_q, wr_addr};
            if (wr_first) begin
                len_d[wr_bank_q] = wr_len;
                byp_d[wr_bank_q] = wr_byp;
            end
            if (wr_cnt_q == last_idx(wr_len)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_cnt_d          = '0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + K'(1);
            end
        end

        if (rd_fire) begin
            if (rd_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_cnt_d          = '0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                rd_cnt_d = rd_cnt_q + K'(1);
            end
        end
    end

    // Control state registers; reset discards any partial or undrained frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q    <= '0;
            len_q     <= {2{LW'(K)}};
            byp_q     <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            full_q    <= full_d;
            len_q     <= len_d;
            byp_q     <= byp_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    // Bank storage write port.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= data_i;
        end
    end

endmodule

// File: tb/tb_bitrev_pp.sv
// Testbench for bitrev_pp: scoreboard of expected output words fed by the
// stimulus driver, consumed by an independent output monitor.
module tb_bitrev_pp;

    localparam int unsigned K  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic [LW-1:0] cfg_log2n_i;
    logic          cfg_bypass_i;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          last_o;
    logic          ready_i;

    bitrev_pp #(.K(K), .DW(DW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .cfg_log2n_i (cfg_log2n_i),
        .cfg_bypass_i(cfg_bypass_i),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .last_o      (last_o),
        .ready_i     (ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t expq[$];
    int   popcyc[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   acc_cnt = 0;
    int   stall_cnt = 0;
    bit   ready_mode = 1'b0;
    logic ready_fix = 1'b0;
    bit   bp_done = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reverse the low l bits of i using plain arithmetic.
    function automatic int rev(input int i, input int l);
        int r = 0;
        int v = i;
        for (int b = 0; b < l; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    // Downstream ready: fixed level or random stalls.
    always @(posedge clk_i) begin
        #1;
        ready_i = ready_mode ? 1'($urandom_range(0, 1)) : ready_fix;
    end

    // Output monitor: every valid cycle must present the scoreboard head.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            if (valid_o) begin
                if (expq.size() == 0) begin
                    chk("unexpected_output", longint'(data_o), -1);
                end else begin
                    chk("out_data", longint'(data_o), longint'(expq[0].d));
                    chk("out_last", longint'(last_o), longint'(expq[0].l));
                    if (ready_i) begin
                        void'(expq.pop_front());
                        popcyc.push_back(cyc);
                    end
                end
            end else begin
                chk("idle_zero", longint'({data_o, last_o}), 0);
            end
        end
    end

    // Build one frame, push its reordered expectation, drive nwords of it.
    task automatic send_frame(input int l, input bit byp, input int base, input bit rnd,
                              input int nwords, input bit push);
        int leff;
        int n;
        bit acc;
        int bound;
        logic [DW-1:0] d[];
        leff = (l == 0 || l > int'(K)) ? int'(K) : l;
        n = 1 << leff;
        d = new[n];
        for (int i = 0; i < n; i++) d[i] = rnd ? DW'($urandom) : DW'(base + i);
        if (push) begin
            for (int i = 0; i < n; i++) begin
                exp_t e;
                e.d = byp ? d[i] : d[rev(i, leff)];
                e.l = (i == n - 1);
                expq.push_back(e);
            end
        end
        for (int i = 0; i < nwords; i++) begin
            valid_i      = 1'b1;
            data_i       = d[i];
            cfg_log2n_i  = LW'(l);
            cfg_bypass_i = byp;
            bound = 0;
            do begin
                @(negedge clk_i);
                acc = ready_o;
                @(posedge clk_i);
                #1;
                if (!acc) stall_cnt++;
                bound++;
            end while (!acc && bound < 500);
            if (!acc) chk("send_timeout", 0, 1);
            else acc_cnt++;
        end
        valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int b = 0;
        while (expq.size() != 0 && b < 3000) begin
            @(posedge clk_i);
            b++;
        end
        chk("drain_timeout", expq.size(), 0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni       = 1'b0;
        valid_i      = 1'b0;
        data_i       = '0;
        cfg_log2n_i  = '0;
        cfg_bypass_i = 1'b0;
        ready_i      = 1'b0;
        #23;
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_last", last_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        ready_fix = 1'b1;
        tick(2);

        // Basic L=4 frame and first-output latency.
        chk("pre_valid", valid_o, 0);
        send_frame(4, 0, 0, 0, 16, 1);
        chk("latency_valid", valid_o, 1);
        chk("latency_first", data_o, 0);
        wait_drain();

        // Back-to-back frames at full rate.
        popcyc.delete();
        stall_cnt = 0;
        send_frame(4, 0, 0, 0, 16, 1);
        send_frame(4, 0, 16, 0, 16, 1);
        wait_drain();
        chk("b2b_stall", stall_cnt, 0);
        chk("b2b_pops", popcyc.size(), 32);
        chk("b2b_gap", (popcyc.size() == 32) ? popcyc[31] - popcyc[0] : -1, 31);

        // Frame-size change and length-0 clamp.
        send_frame(2, 0, 0, 0, 4, 1);
        send_frame(4, 0, 100, 0, 16, 1);
        send_frame(0, 0, 500, 0, 16, 1);
        wait_drain();

        // Bypass then normal at L=3.
        send_frame(3, 1, 0, 0, 8, 1);
        send_frame(3, 0, 8, 0, 8, 1);
        wait_drain();

        // Backpressure: both banks fill, then random drain stalls.
        ready_fix = 1'b0;
        tick(2);
        acc_cnt = 0;
        bp_done = 1'b0;
        fork
            begin
                send_frame(4, 0, 0, 0, 16, 1);
                send_frame(4, 0, 16, 0, 16, 1);
                send_frame(4, 0, 32, 0, 16, 1);
                bp_done = 1'b1;
            end
        join_none
        tick(60);
        chk("bp_accepted", acc_cnt, 32);
        chk("bp_ready_low", ready_o, 0);
        ready_mode = 1'b1;
        begin
            int b = 0;
            while (!bp_done && b < 2000) begin
                @(posedge clk_i);
                b++;
            end
        end
        chk("bp_done", bp_done, 1);
        wait_drain();
        chk("bp_total", acc_cnt, 48);

        // Randomized frames: random length (incl. clamped codes), bypass, data, stalls.
        for (int f = 0; f < 10; f++) begin
            int l;
            int leff;
            l = $urandom_range(0, 7);
            leff = (l == 0 || l > int'(K)) ? int'(K) : l;
            send_frame(l, 1'($urandom_range(0, 1)), 0, 1, 1 << leff, 1);
        end
        wait_drain();

        // Reset while one frame drains and another is partially written.
        ready_mode = 1'b0;
        ready_fix  = 1'b0;
        tick(2);
        send_frame(4, 0, 200, 0, 16, 1);
        ready_fix = 1'b1;
        send_frame(4, 0, 300, 0, 5, 0);
        #1;
        rst_ni = 1'b0;
        expq.delete();
        #1;
        chk("mid_rst_ready", ready_o, 1);
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_data", data_o, 0);
        chk("mid_rst_last", last_o, 0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        tick(1);
        send_frame(4, 0, 0, 0, 16, 1);
        wait_drain();
        tick(20);
        chk("no_stale", valid_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
